// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one nibble-serial ALU between N_REQ requesters.
// Optional: define ALU_WATCHDOG_EN for a START/RUN timeout with a sticky wdog_err flag.
module alu_share_arbiter #(
    parameter int N_REQ       = 3,
    parameter int CTRL_W      = 4,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CTRL_W-1:0]  req_ctrl,
    input  logic [N_REQ*32-1:0]      req_w1,
    input  logic [N_REQ*32-1:0]      req_w2,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic [31:0]              result,
    output logic [CTRL_W-1:0]        alu_ctrl,
    output logic [31:0]              alu_w1,
    output logic [31:0]              alu_w2,
    output logic                     alu_perm_to_count,
    input  logic                     alu_busy,
`ifdef ALU_WATCHDOG_EN
    output logic                     wdog_err,
`endif
    input  logic [31:0]              alu_result
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t              r_state;
    logic [IW-1:0]       r_last;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_done;
    logic [31:0]         r_result;
    logic [31:0]         r_w1;
    logic [31:0]         r_w2;
    logic [CTRL_W-1:0]   r_ctrl;
    logic                r_perm;

    logic                w_any;
    logic [IW-1:0]       w_idx;
    logic [IW:0]         w_s;
    logic [N_REQ-1:0]    w_oh;
    logic [CTRL_W-1:0]   w_ctrl;
    logic [31:0]         w_w1;
    logic [31:0]         w_w2;

`ifdef ALU_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0]       r_wdog;
    logic                r_wdog_err;
    assign wdog_err = r_wdog_err;
`endif

    assign gnt               = r_gnt;
    assign done              = r_done;
    assign result            = r_result;
    assign alu_ctrl          = r_ctrl;
    assign alu_w1            = r_w1;
    assign alu_w2            = r_w2;
    assign alu_perm_to_count = r_perm;

    // Round-robin pick: scan down so the slot right after r_last is assigned last and wins.
    always_comb begin
        w_any = 1'b0;
        w_idx = '0;
        w_s   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_s = {1'b0, r_last} + (IW+1)'(k);
            if (w_s >= (IW+1)'(N_REQ))
                w_s = w_s - (IW+1)'(N_REQ);
            if (req[w_s[IW-1:0]]) begin
                w_any = 1'b1;
                w_idx = w_s[IW-1:0];
            end
        end
    end

    // Select the winner's operand slot and build its one-hot grant.
    always_comb begin
        w_oh   = '0;
        w_ctrl = '0;
        w_w1   = '0;
        w_w2   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_any && (w_idx == IW'(i))) begin
                w_oh[i] = 1'b1;
                w_ctrl  = req_ctrl[i*CTRL_W +: CTRL_W];
                w_w1    = req_w1[i*32 +: 32];
                w_w2    = req_w2[i*32 +: 32];
            end
        end
    end

    // Arbitration and ALU handshake sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= IW'(N_REQ - 1);
            r_gnt    <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_w1     <= '0;
            r_w2     <= '0;
            r_ctrl   <= '0;
            r_perm   <= 1'b0;
`ifdef ALU_WATCHDOG_EN
            r_wdog     <= '0;
            r_wdog_err <= 1'b0;
`endif
        end else begin
            r_done <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ctrl  <= w_ctrl;
                        r_w1    <= w_w1;
                        r_w2    <= w_w2;
                        r_gnt   <= w_oh;
                        r_last  <= w_idx;
                        r_perm  <= 1'b1;
                        r_state <= S_START;
`ifdef ALU_WATCHDOG_EN
                        r_wdog  <= '0;
`endif
                    end
                end
                S_START: begin
                    if (alu_busy)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!alu_busy) begin
                        r_result <= alu_result;
                        r_perm   <= 1'b0;
                        r_done   <= r_gnt;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef ALU_WATCHDOG_EN
            if (r_state == S_START || (r_state == S_RUN && alu_busy)) begin
                if (r_wdog == WW'(WDOG_CYCLES - 1)) begin
                    r_wdog_err <= 1'b1;
                    r_perm     <= 1'b0;
                    r_result   <= 32'hDEAD_BEEF;
                    r_done     <= r_gnt;
                    r_state    <= S_DONE;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: random requesters plus a busy-for-8-cycles ALU model,
// checked against a transaction-level round-robin reference.
module tb_alu_share_arbiter;

    localparam int N  = 3;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*CW-1:0] req_ctrl;
    logic [N*32-1:0] req_w1;
    logic [N*32-1:0] req_w2;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     result;
    logic [CW-1:0]   alu_ctrl;
    logic [31:0]     alu_w1;
    logic [31:0]     alu_w2;
    logic            alu_perm_to_count;
    logic            alu_busy;
    logic [31:0]     alu_result;
`ifdef ALU_WATCHDOG_EN
    logic            wdog_err;
`endif

    alu_share_arbiter #(.N_REQ(N), .CTRL_W(CW), .WDOG_CYCLES(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .req_ctrl          (req_ctrl),
        .req_w1            (req_w1),
        .req_w2            (req_w2),
        .gnt               (gnt),
        .done              (done),
        .result            (result),
        .alu_ctrl          (alu_ctrl),
        .alu_w1            (alu_w1),
        .alu_w2            (alu_w2),
        .alu_perm_to_count (alu_perm_to_count),
        .alu_busy          (alu_busy),
`ifdef ALU_WATCHDOG_EN
        .wdog_err          (wdog_err),
`endif
        .alu_result        (alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] aluf(input logic [3:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ALU model: busy rises the edge after perm, stays high 8 cycles.
    logic        a_busy;
    logic        a_fin;
    logic        alu_dead;
    int          a_cnt;
    logic [31:0] a_res;
    logic [31:0] a_junk;

    assign alu_busy   = a_busy;
    assign alu_result = a_busy ? a_junk : a_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_busy <= 1'b0;
            a_fin  <= 1'b0;
            a_cnt  <= 0;
            a_res  <= '0;
            a_junk <= '0;
        end else begin
            a_junk <= $urandom;
            if (!alu_perm_to_count)
                a_fin <= 1'b0;
            if (alu_perm_to_count && !a_busy && !a_fin && !alu_dead) begin
                a_busy <= 1'b1;
                a_cnt  <= 7;
                a_res  <= aluf(alu_ctrl, alu_w1, alu_w2);
            end else if (a_busy) begin
                if (a_cnt == 0) begin
                    a_busy <= 1'b0;
                    a_fin  <= 1'b1;
                end else begin
                    a_cnt <= a_cnt - 1;
                end
            end
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Requester state and reference model.
    logic [3:0]  op_c [N];
    logic [31:0] op_a [N];
    logic [31:0] op_b [N];
    bit          pend [N];
    bit          m_act;
    int          m_t;
    int          m_own;
    int          m_last;
    logic [31:0] m_res;
    logic [31:0] m_w1;
    logic [N-1:0] req_seen;

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_ctrl[i*CW +: CW] = op_c[i];
            req_w1[i*32 +: 32]   = op_a[i];
            req_w2[i*32 +: 32]   = op_b[i];
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_t    = 0;
        m_last = N - 1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        req = '0;
    endtask

    // One clock: advance the transaction model and compare.
    task automatic cycle();
        req_seen = req;
        @(posedge clk);
        #1;
        if (m_act) begin
            m_t++;
            if (m_t < 10) begin
                chk("gnt_hold", gnt, oh(m_own));
                chk("done_early", done, '0);
                chk("perm_run", alu_perm_to_count, 1);
            end else if (m_t == 10) begin
                chk("done_pulse", done, oh(m_own));
                chk("result", result, m_res);
                chk("perm_done", alu_perm_to_count, 0);
                chk("gnt_done", gnt, oh(m_own));
                pend[m_own] = 1'b0;
            end else begin
                chk("gnt_clr", gnt, '0);
                chk("done_once", done, '0);
                chk("w1_hold", alu_w1, m_w1);
                m_act = 1'b0;
            end
        end else begin
            chk("done_idle", done, '0);
            if (req_seen != '0) begin
                for (int k = 1; k <= N; k++) begin
                    if (!m_act && req_seen[(m_last + k) % N]) begin
                        m_own = (m_last + k) % N;
                        m_act = 1'b1;
                    end
                end
                m_last = m_own;
                m_t    = 0;
                m_res  = aluf(op_c[m_own], op_a[m_own], op_b[m_own]);
                m_w1   = op_a[m_own];
                chk("gnt_pick", gnt, oh(m_own));
                chk("alu_w1", alu_w1, op_a[m_own]);
                chk("alu_ctrl", alu_ctrl, op_c[m_own]);
                chk("perm_start", alu_perm_to_count, 1);
            end else begin
                chk("gnt_idle", gnt, '0);
            end
        end
    endtask

    // mode 0: random requesters, 1: all re-request, 2: no new requests.
    task automatic stim(input int mode);
        for (int i = 0; i < N; i++) begin
            if (m_act && m_own == i && m_t == 0 && ($urandom % 2 == 0))
                op_a[i] = $urandom;
            if (m_act && m_own == i && m_t == 5 && ($urandom % 6 == 0))
                req[i] = 1'b0;
            if (!pend[i]) begin
                if (mode == 1 || (mode == 0 && $urandom % 4 == 0)) begin
                    pend[i] = 1'b1;
                    op_c[i] = 4'($urandom % 5);
                    op_a[i] = $urandom;
                    op_b[i] = $urandom;
                    req[i]  = 1'b1;
                end else begin
                    req[i] = 1'b0;
                end
            end
        end
        pack();
    endtask

    initial begin
        alu_dead = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_c[i] = '0;
            op_a[i] = '0;
            op_b[i] = '0;
        end
        pack();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, '0);
        chk("rst_done", done, '0);
        chk("rst_perm", alu_perm_to_count, 0);
        chk("rst_result", result, '0);
        chk("rst_w1", alu_w1, '0);
`ifdef ALU_WATCHDOG_EN
        chk("rst_wdog", wdog_err, 0);
`endif
        rst = 1'b0;

        // Single request: 4 + 1.
        pend[0] = 1'b1;
        op_c[0] = 4'd0;
        op_a[0] = 32'd4;
        op_b[0] = 32'd1;
        req     = 3'b001;
        pack();
        repeat (14) begin
            cycle();
            stim(2);
        end

        // All requesters continuously: strict rotation.
        repeat (60) begin
            cycle();
            stim(1);
        end

        repeat (200) begin
            cycle();
            stim(0);
        end

        // Reset in the middle of RUN.
        begin
            int guard;
            guard = 0;
            while (!(m_act && m_t == 5) && guard < 200) begin
                cycle();
                stim(1);
                guard++;
            end
            chk("rst_wait", m_act && m_t == 5, 1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", gnt, '0);
        chk("mid_rst_perm", alu_perm_to_count, 0);
        chk("mid_rst_result", result, '0);
        chk("mid_rst_done", done, '0);
        @(posedge clk);
        #1;
        chk("mid_rst_done2", done, '0);
        rst = 1'b0;
        model_reset();

        // Only requester 1 after reset.
        pend[1] = 1'b1;
        op_c[1] = 4'd0;
        op_a[1] = 32'd123;
        op_b[1] = 32'd2;
        req     = 3'b010;
        pack();
        repeat (14) begin
            cycle();
            stim(2);
        end

        repeat (150) begin
            cycle();
            stim(0);
        end

        begin
            int guard;
            guard = 0;
            while (m_act && guard < 20) begin
                cycle();
                stim(2);
                guard++;
            end
            chk("drain", m_act, 0);
        end

`ifdef ALU_WATCHDOG_EN
        begin
            int t;
            req = '0;
            repeat (2) cycle();
            alu_dead = 1'b1;
            op_c[0] = 4'd0;
            op_a[0] = 32'd7;
            op_b[0] = 32'd7;
            pack();
            req = 3'b001;
            @(posedge clk);
            #1;
            chk("wd_gnt", gnt, 3'b001);
            t = 0;
            while (done == '0 && t < 40) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("wd_latency", t, 16);
            chk("wd_done", done, 3'b001);
            chk("wd_result", result, 32'hDEAD_BEEF);
            chk("wd_err", wdog_err, 1);
            chk("wd_perm", alu_perm_to_count, 0);
            req = '0;
            repeat (3) @(posedge clk);
            #1;
            chk("wd_sticky", wdog_err, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
